// File: rtl/apu_pkg.sv
// Shared register addresses, read-back masks and the square-channel configuration bundle
// for the sound-chip register controller.
package apu_pkg;

    localparam logic [7:0] NR10_A = 8'h10;
    localparam logic [7:0] NR11_A = 8'h11;
    localparam logic [7:0] NR12_A = 8'h12;
    localparam logic [7:0] NR13_A = 8'h13;
    localparam logic [7:0] NR14_A = 8'h14;
    localparam logic [7:0] NR21_A = 8'h16;
    localparam logic [7:0] NR22_A = 8'h17;
    localparam logic [7:0] NR23_A = 8'h18;
    localparam logic [7:0] NR24_A = 8'h19;
    localparam logic [7:0] NR50_A = 8'h24;
    localparam logic [7:0] NR51_A = 8'h25;
    localparam logic [7:0] NR52_A = 8'h26;

    // Bits forced to 1 on read-back; write-only bits always read as 1.
    localparam logic [7:0] MASK_NR10     = 8'h80;
    localparam logic [7:0] MASK_NRX1     = 8'h3F;
    localparam logic [7:0] MASK_NRX2     = 8'h00;
    localparam logic [7:0] MASK_NRX3     = 8'hFF;
    localparam logic [7:0] MASK_NRX4     = 8'hBF;
    localparam logic [7:0] MASK_NR50     = 8'h00;
    localparam logic [7:0] MASK_NR51     = 8'h00;
    localparam logic [7:0] MASK_UNMAPPED = 8'hFF;

    typedef struct packed {
        logic [1:0]  duty;
        logic [5:0]  len_load;
        logic [3:0]  start_vol;
        logic        env_add;
        logic [2:0]  period;
        logic [10:0] freq;
        logic        len_enable;
    } sq_cfg_t;

endpackage

// File: rtl/apu_reg_ctrl_if.sv
// CPU-side byte bus into the sound-chip register controller.
interface apu_reg_ctrl_if #(
    parameter int ADDR_W = 8
) ();
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic [7:0]        rdata;
    logic              rvalid;

    modport master (output wr_en, rd_en, addr, wdata, input rdata, rvalid);
    modport slave  (input wr_en, rd_en, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/apu_sq_regs.sv
// One square channel's NRx1..NRx4 registers: field decode, trigger strobe and read-back.
module apu_sq_regs
    import apu_pkg::*;
#(
    parameter int                ADDR_W = 8,
    parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(NR11_A)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              clear,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output sq_cfg_t           cfg,
    output logic              trigger,
    output logic              rd_hit,
    output logic [7:0]        rd_byte
);

    logic [7:0] nr1, nr2, nr3;
    logic       len_en;
    logic [2:0] freq_hi;
    logic       hit1, hit2, hit3, hit4;

    assign hit1 = (addr == BASE);
    assign hit2 = (addr == BASE + ADDR_W'(1));
    assign hit3 = (addr == BASE + ADDR_W'(2));
    assign hit4 = (addr == BASE + ADDR_W'(3));

    // NRx4 bit 7 only fires the strobe; it is never stored.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            nr1     <= 8'h00;
            nr2     <= 8'h00;
            nr3     <= 8'h00;
            len_en  <= 1'b0;
            freq_hi <= 3'd0;
            trigger <= 1'b0;
        end else begin
            trigger <= wr_en && hit4 && wdata[7];
            if (wr_en && hit1) nr1 <= wdata;
            if (wr_en && hit2) nr2 <= wdata;
            if (wr_en && hit3) nr3 <= wdata;
            if (wr_en && hit4) begin
                len_en  <= wdata[6];
                freq_hi <= wdata[2:0];
            end
        end
    end

    assign cfg.duty       = nr1[7:6];
    assign cfg.len_load   = nr1[5:0];
    assign cfg.start_vol  = nr2[7:4];
    assign cfg.env_add    = nr2[3];
    assign cfg.period     = nr2[2:0];
    assign cfg.freq       = {freq_hi, nr3};
    assign cfg.len_enable = len_en;

    always_comb begin
        rd_hit  = 1'b1;
        rd_byte = MASK_UNMAPPED;
        if (hit1)      rd_byte = nr1 | MASK_NRX1;
        else if (hit2) rd_byte = nr2 | MASK_NRX2;
        else if (hit3) rd_byte = nr3 | MASK_NRX3;
        else if (hit4) rd_byte = {1'b0, len_en, 6'b000000} | MASK_NRX4;
        else           rd_hit  = 1'b0;
    end

endmodule

// File: rtl/apu_reg_ctrl.sv
// Sound-chip register file: decodes CPU byte writes into channel/mixer control fields,
// handles master power-off clearing and returns masked read-back data.
module apu_reg_ctrl
    import apu_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter bit POWER_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    apu_reg_ctrl_if.slave        bus,
    input  logic                 sq1_active,
    input  logic                 sq2_active,
    output logic [2:0]           sq1_swpPd,
    output logic                 sq1_negate,
    output logic [2:0]           sq1_shift,
    output logic [1:0]           sq1_duty,
    output logic [5:0]           sq1_lenLoad,
    output logic [3:0]           sq1_startVol,
    output logic                 sq1_envAdd,
    output logic [2:0]           sq1_period,
    output logic [10:0]          sq1_freq,
    output logic                 sq1_lenEnable,
    output logic                 sq1_trigger,
    output logic [1:0]           sq2_duty,
    output logic [5:0]           sq2_lenLoad,
    output logic [3:0]           sq2_startVol,
    output logic                 sq2_envAdd,
    output logic [2:0]           sq2_period,
    output logic [10:0]          sq2_freq,
    output logic                 sq2_lenEnable,
    output logic                 sq2_trigger,
    output logic [2:0]           vol_left,
    output logic [2:0]           vol_right,
    output logic [7:0]           pan,
    output logic                 power
);

    logic [6:0] nr10;
    logic [7:0] nr50, nr51;
    logic       power_q;
    logic       wr_ok, clear, nr52_wr;
    sq_cfg_t    sq1_cfg, sq2_cfg;
    logic       sq1_hit, sq2_hit;
    logic [7:0] sq1_rd, sq2_rd, rd_val;

    assign nr52_wr = bus.wr_en && (bus.addr == ADDR_W'(NR52_A));
    assign wr_ok   = bus.wr_en && power_q;
    // Power-off edge wipes every register and kills any pending trigger.
    assign clear   = nr52_wr && power_q && !bus.wdata[7];

    always_ff @(posedge clk) begin
        if (reset) begin
            nr10    <= 7'd0;
            nr50    <= 8'h00;
            nr51    <= 8'h00;
            power_q <= POWER_ON_RESET;
        end else begin
            if (nr52_wr) power_q <= bus.wdata[7];
            if (clear) begin
                nr10 <= 7'd0;
                nr50 <= 8'h00;
                nr51 <= 8'h00;
            end else if (wr_ok) begin
                if (bus.addr == ADDR_W'(NR10_A)) nr10 <= bus.wdata[6:0];
                if (bus.addr == ADDR_W'(NR50_A)) nr50 <= bus.wdata;
                if (bus.addr == ADDR_W'(NR51_A)) nr51 <= bus.wdata;
            end
        end
    end

    apu_sq_regs #(.ADDR_W(ADDR_W), .BASE(ADDR_W'(NR11_A))) u_sq1 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_ok),
        .clear   (clear),
        .addr    (bus.addr),
        .wdata   (bus.wdata),
        .cfg     (sq1_cfg),
        .trigger (sq1_trigger),
        .rd_hit  (sq1_hit),
        .rd_byte (sq1_rd)
    );

    apu_sq_regs #(.ADDR_W(ADDR_W), .BASE(ADDR_W'(NR21_A))) u_sq2 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_ok),
        .clear   (clear),
        .addr    (bus.addr),
        .wdata   (bus.wdata),
        .cfg     (sq2_cfg),
        .trigger (sq2_trigger),
        .rd_hit  (sq2_hit),
        .rd_byte (sq2_rd)
    );

    always_comb begin
        rd_val = MASK_UNMAPPED;
        if (sq1_hit)                          rd_val = sq1_rd;
        else if (sq2_hit)                     rd_val = sq2_rd;
        else if (bus.addr == ADDR_W'(NR10_A)) rd_val = {1'b0, nr10} | MASK_NR10;
        else if (bus.addr == ADDR_W'(NR50_A)) rd_val = nr50 | MASK_NR50;
        else if (bus.addr == ADDR_W'(NR51_A)) rd_val = nr51 | MASK_NR51;
        else if (bus.addr == ADDR_W'(NR52_A)) rd_val = {power_q, 3'b111, 2'b00, sq2_active, sq1_active};
    end

    // Read samples current (pre-write) state, so a same-cycle write is not seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rvalid <= 1'b0;
            bus.rdata  <= 8'h00;
        end else begin
            bus.rvalid <= bus.rd_en;
            bus.rdata  <= bus.rd_en ? rd_val : 8'h00;
        end
    end

    assign sq1_swpPd     = nr10[6:4];
    assign sq1_negate    = nr10[3];
    assign sq1_shift     = nr10[2:0];
    assign sq1_duty      = sq1_cfg.duty;
    assign sq1_lenLoad   = sq1_cfg.len_load;
    assign sq1_startVol  = sq1_cfg.start_vol;
    assign sq1_envAdd    = sq1_cfg.env_add;
    assign sq1_period    = sq1_cfg.period;
    assign sq1_freq      = sq1_cfg.freq;
    assign sq1_lenEnable = sq1_cfg.len_enable;
    assign sq2_duty      = sq2_cfg.duty;
    assign sq2_lenLoad   = sq2_cfg.len_load;
    assign sq2_startVol  = sq2_cfg.start_vol;
    assign sq2_envAdd    = sq2_cfg.env_add;
    assign sq2_period    = sq2_cfg.period;
    assign sq2_freq      = sq2_cfg.freq;
    assign sq2_lenEnable = sq2_cfg.len_enable;
    assign vol_left      = nr50[6:4];
    assign vol_right     = nr50[2:0];
    assign pan           = nr51;
    assign power         = power_q;

endmodule

// File: tb/tb_apu_reg_ctrl.sv
// Scoreboard bench for apu_reg_ctrl: reads and trigger strobes are queued at issue time
// and checked by a negedge monitor; field outputs are checked directly after writes.
module tb_apu_reg_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sq1_active = 1'b0;
    logic sq2_active = 1'b0;
    always #5 clk = ~clk;

    apu_reg_ctrl_if #(.ADDR_W(8)) bus ();

    logic [2:0]  sq1_swpPd, sq1_shift, sq1_period, sq2_period, vol_left, vol_right;
    logic        sq1_negate, sq1_envAdd, sq2_envAdd, sq1_lenEnable, sq2_lenEnable;
    logic        sq1_trigger, sq2_trigger, power;
    logic [1:0]  sq1_duty, sq2_duty;
    logic [5:0]  sq1_lenLoad, sq2_lenLoad;
    logic [3:0]  sq1_startVol, sq2_startVol;
    logic [10:0] sq1_freq, sq2_freq;
    logic [7:0]  pan;

    apu_reg_ctrl #(.ADDR_W(8), .POWER_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .sq1_active(sq1_active), .sq2_active(sq2_active),
        .sq1_swpPd(sq1_swpPd), .sq1_negate(sq1_negate), .sq1_shift(sq1_shift),
        .sq1_duty(sq1_duty), .sq1_lenLoad(sq1_lenLoad), .sq1_startVol(sq1_startVol),
        .sq1_envAdd(sq1_envAdd), .sq1_period(sq1_period), .sq1_freq(sq1_freq),
        .sq1_lenEnable(sq1_lenEnable), .sq1_trigger(sq1_trigger),
        .sq2_duty(sq2_duty), .sq2_lenLoad(sq2_lenLoad), .sq2_startVol(sq2_startVol),
        .sq2_envAdd(sq2_envAdd), .sq2_period(sq2_period), .sq2_freq(sq2_freq),
        .sq2_lenEnable(sq2_lenEnable), .sq2_trigger(sq2_trigger),
        .vol_left(vol_left), .vol_right(vol_right), .pan(pan), .power(power)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit pwr_m = 1'b1;
    logic [7:0] rd_q[$];
    int t1_q[$];
    int t2_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rvalid and every trigger pulse must match a queued expectation.
    always @(negedge clk) begin
        if (bus.rvalid) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rvalid_unexpected: rdata %0h with no read pending", bus.rdata);
            end else begin
                chk("rdata", {24'd0, bus.rdata}, {24'd0, rd_q.pop_front()});
            end
        end
        if (sq1_trigger) begin
            if (t1_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sq1_trigger_unexpected: pulse at cycle %0d, none expected", cyc);
            end else chk("sq1_trigger_cycle", cyc, t1_q.pop_front());
        end else if (t1_q.size() != 0 && t1_q[0] <= cyc) begin
            checks++; errors++;
            $display("FAIL sq1_trigger_missing: got none expected pulse at cycle %0d", t1_q.pop_front());
        end
        if (sq2_trigger) begin
            if (t2_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sq2_trigger_unexpected: pulse at cycle %0d, none expected", cyc);
            end else chk("sq2_trigger_cycle", cyc, t2_q.pop_front());
        end else if (t2_q.size() != 0 && t2_q[0] <= cyc) begin
            checks++; errors++;
            $display("FAIL sq2_trigger_missing: got none expected pulse at cycle %0d", t2_q.pop_front());
        end
    end

    task automatic xfer(input bit w, input bit r, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] exp);
        bus.wr_en = w; bus.rd_en = r; bus.addr = a; bus.wdata = d;
        if (r) rd_q.push_back(exp);
        if (w) begin
            if (pwr_m && d[7] && a == 8'h14) t1_q.push_back(cyc + 1);
            if (pwr_m && d[7] && a == 8'h19) t2_q.push_back(cyc + 1);
            if (a == 8'h26) pwr_m = d[7];
        end
        @(posedge clk); #1;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        xfer(1'b1, 1'b0, a, d, 8'h00);
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp);
        xfer(1'b0, 1'b1, a, 8'h00, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = 8'h00; bus.wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_power", power, 1);
        chk("reset_sq1_freq", sq1_freq, 0);
        chk("reset_pan", pan, 0);
        chk("reset_rvalid", bus.rvalid, 0);

        rd(8'h26, 8'hF0);
        rd(8'h11, 8'h3F);
        rd(8'h20, 8'hFF);
        rd(8'h10, 8'h80);
        rd(8'h13, 8'hFF);
        sq1_active = 1'b1;
        rd(8'h26, 8'hF1);
        sq2_active = 1'b1;
        rd(8'h26, 8'hF3);
        sq1_active = 1'b0; sq2_active = 1'b0;

        wr(8'h11, 8'h80);
        wr(8'h12, 8'hF3);
        wr(8'h13, 8'h83);
        wr(8'h14, 8'hC7);
        chk("sq1_duty", sq1_duty, 2);
        chk("sq1_lenLoad", sq1_lenLoad, 0);
        chk("sq1_startVol", sq1_startVol, 15);
        chk("sq1_envAdd", sq1_envAdd, 0);
        chk("sq1_period", sq1_period, 3);
        chk("sq1_freq", sq1_freq, 11'h783);
        chk("sq1_lenEnable", sq1_lenEnable, 1);
        rd(8'h14, 8'hFF);
        rd(8'h12, 8'hF3);
        rd(8'h11, 8'hBF);

        wr(8'h10, 8'h7A);
        chk("sq1_swpPd", sq1_swpPd, 7);
        chk("sq1_negate", sq1_negate, 1);
        chk("sq1_shift", sq1_shift, 2);
        rd(8'h10, 8'hFA);

        wr(8'h19, 8'h05);
        chk("sq2_freq_hi", sq2_freq, 11'h500);
        wr(8'h16, 8'h55);
        chk("sq2_duty", sq2_duty, 1);
        chk("sq2_lenLoad", sq2_lenLoad, 6'h15);
        wr(8'h17, 8'h2C);
        chk("sq2_startVol", sq2_startVol, 2);
        chk("sq2_envAdd", sq2_envAdd, 1);
        chk("sq2_period", sq2_period, 4);
        wr(8'h18, 8'hAA);
        chk("sq2_freq_lo", sq2_freq, 11'h5AA);
        wr(8'h19, 8'h80);
        chk("sq2_freq_trig", sq2_freq, 11'h0AA);
        chk("sq2_lenEnable", sq2_lenEnable, 0);

        wr(8'h24, 8'h77);
        wr(8'h25, 8'hF3);
        chk("vol_left", vol_left, 7);
        chk("vol_right", vol_right, 7);
        chk("pan", pan, 8'hF3);
        rd(8'h24, 8'h77);

        wr(8'h26, 8'h00);
        chk("off_power", power, 0);
        chk("off_sq1_freq", sq1_freq, 0);
        chk("off_sq1_duty", sq1_duty, 0);
        chk("off_sq1_swpPd", sq1_swpPd, 0);
        chk("off_sq2_freq", sq2_freq, 0);
        chk("off_pan", pan, 0);
        chk("off_vol_left", vol_left, 0);
        rd(8'h26, 8'h70);
        wr(8'h12, 8'hF0);
        chk("off_write_ignored", sq1_startVol, 0);
        rd(8'h12, 8'h00);
        wr(8'h14, 8'h80);
        wr(8'h26, 8'h80);
        chk("on_power", power, 1);
        chk("on_sq1_freq", sq1_freq, 0);
        rd(8'h26, 8'hF0);

        wr(8'h14, 8'h80);
        wr(8'h26, 8'h00);
        wr(8'h26, 8'h80);

        xfer(1'b1, 1'b1, 8'h14, 8'h80, 8'hBF);
        xfer(1'b1, 1'b1, 8'h14, 8'h40, 8'hBF);
        rd(8'h14, 8'hFF);
        wr(8'h14, 8'h80);
        wr(8'h14, 8'h80);
        chk("b2b_lenEnable", sq1_lenEnable, 0);

        wr(8'h24, 8'h55);
        wr(8'h13, 8'h12);
        bus.wr_en = 1'b1; bus.addr = 8'h14; bus.wdata = 8'h80; reset = 1'b1;
        @(posedge clk); #1;
        bus.wr_en = 1'b0; reset = 1'b0;
        pwr_m = 1'b1;
        chk("rst_power", power, 1);
        chk("rst_vol_left", vol_left, 0);
        chk("rst_sq1_freq", sq1_freq, 0);
        chk("rst_rvalid", bus.rvalid, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rd_queue_drained", rd_q.size(), 0);
        chk("t1_queue_drained", t1_q.size(), 0);
        chk("t2_queue_drained", t2_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apu_reg_ctrl.md
Name: apu_reg_ctrl

Overview:
- CPU-facing register file and configuration controller for the sound chip.
- Decodes byte writes to NR10–NR14 (square 1), NR21–NR24 (square 2) and NR50–NR52 (master) into the level-type control fields the pulse channels and mixer consume.
- Generates one-cycle trigger strobes, implements master power-off clearing, and returns CPU reads with hardware read-back masks.
- Sits between the CPU bus and pulseChannel1/pulseChannel2/mixer; replaces the per-time-step stimulus arrays in the top level.

Parameters:
- ADDR_W, 8, width of the low address byte (register at 0xFF00 + addr).
- POWER_ON_RESET, 1, value of NR52 bit 7 after reset (1 = powered).

Ports:
- clk  in  1  system clock (4.194304 MHz domain)
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe, one cycle per write
- rd_en  in  1  read strobe, one cycle per read
- addr  in  ADDR_W  register address low byte
- wdata  in  8  write data
- rdata  out  8  read data, valid when rvalid = 1
- rvalid  out  1  read-data valid, one cycle
- sq1_active, sq2_active  in  1 each  channel-running status, for NR52 read-back
- sq1_swpPd[3], sq1_negate[1], sq1_shift[3]  out  NR10 fields
- sq1_duty[2], sq1_lenLoad[6]  out  NR11 fields
- sq1_startVol[4], sq1_envAdd[1], sq1_period[3]  out  NR12 fields
- sq1_freq  out  11  {NR14[2:0], NR13}
- sq1_lenEnable  out  1  NR14 bit 6
- sq1_trigger  out  1  one-cycle trigger strobe
- sq2_duty, sq2_lenLoad, sq2_startVol, sq2_envAdd, sq2_period, sq2_freq, sq2_lenEnable, sq2_trigger  out  same widths as sq1, from NR21–NR24
- vol_left, vol_right  out  3 each  NR50[6:4], NR50[2:0]
- pan  out  8  NR51
- power  out  1  NR52 bit 7

Behaviour:
- Register map: 0x10 NR10, 0x11 NR11, 0x12 NR12, 0x13 NR13, 0x14 NR14, 0x16 NR21, 0x17 NR22, 0x18 NR23, 0x19 NR24, 0x24 NR50, 0x25 NR51, 0x26 NR52. Every other address is unmapped.
- Reset:
  - All register bytes = 0x00; power = POWER_ON_RESET; all outputs 0 except power.
  - rdata = 0x00, rvalid = 0.
  - Reset dominates any concurrent wr_en/rd_en.
- Write latency:
  - A write on cycle N updates the stored byte and the field outputs at edge N, visible from cycle N+1.
  - Writes to unmapped addresses are ignored.
- Trigger strobes:
  - A write to NR14 (NR24) with wdata[7] = 1 while powered drives sq1_trigger (sq2_trigger) high for exactly cycle N+1.
  - The new freq, lenEnable and all other fields are already valid in that cycle.
  - Bit 7 is never stored.
  - Back-to-back trigger writes give back-to-back strobes.
- Power:
  - A write to NR52 stores only bit 7; other bits are ignored.
  - A 1→0 transition clears NR10–NR51 to 0x00 on the same edge. Any trigger strobe scheduled for the next cycle is suppressed.
  - While power = 0, writes to NR10–NR51 are ignored; only NR52 is writable.
  - A 0→1 transition does not restore prior values.
- Reads:
  - rd_en on cycle N gives rvalid = 1 and rdata on cycle N+1.
  - rdata = stored byte OR read mask.
  - Masks: NR10 0x80, NR11 0x3F, NR12 0x00, NR13 0xFF, NR14 0xBF, NR21 0x3F, NR22 0x00, NR23 0xFF, NR24 0xBF, NR50 0x00, NR51 0x00, unmapped 0xFF.
  - NR52 reads {power, 3'b111, 2'b00, sq2_active, sq1_active}, sampled on cycle N.
- Simultaneous rd_en and wr_en to the same address: the read returns the pre-write value.
- rvalid is low in every cycle without a preceding rd_en.
- Out-of-range field combinations are passed through unchanged; the channels own their semantics.

Decomposition:
- Package apu_pkg holds:
  - register address localparams (NR10_A … NR52_A);
  - read-mask localparams;
  - a packed struct type for a square-channel configuration bundle (duty, lenLoad, startVol, envAdd, period, freq, lenEnable).
- Natural sub-module: apu_sq_regs, one instance per square channel. It holds the four bytes NRx1–NRx4, decodes the channel fields, and generates the trigger strobe.
- NR10 sweep fields and the master registers stay in the top module.

Test Plan:
- Reset, then read 0x26 with sq*_active = 0 → rdata 0xF0 at cycle N+1; read 0x11 → 0x3F; read 0x20 → 0xFF.
- Write 0x11 = 0x80, 0x12 = 0xF3, 0x13 = 0x83, then 0x14 = 0xC7 → cycle after the NR14 write: sq1_duty 2, sq1_startVol 15, sq1_envAdd 0, sq1_period 3, sq1_freq 0x783, sq1_lenEnable 1, sq1_trigger high exactly 1 cycle. Read 0x14 → 0xFF.
- Write 0x19 = 0x05 (no bit 7) → sq2_freq[10:8] = 5, sq2_trigger stays 0.
- Write 0x24 = 0x77, 0x25 = 0xF3 → vol_left 7, vol_right 7, pan 0xF3. Then write 0x26 = 0x00 → all fields 0, power 0. Write 0x12 = 0xF0 → ignored (reads 0x00). Write 0x26 = 0x80 → power 1, fields still 0.
- Write 0x14 = 0x80 in cycle N and 0x26 = 0x00 in cycle N+1 → trigger high cycle N+1 only. Write 0x14 = 0x80 and read 0x14 in the same cycle → rdata 0xBF (old value) next cycle.
- Assert reset during a cycle with wr_en to 0x14 = 0x80 → no trigger pulse, all outputs 0, power = POWER_ON_RESET.
